mem_responder: RTL and testbench

- Word-addressed 16-bit memory that acts as the responder end of the CPU memory bus (`read_m`, `write_m`, `address`, bidirectional `data`).
- Serves instruction fetches, loads and stores with a configurable read latency.
- Provides a preload port for the testbench and sticky error reporting.
- Keeps saturating access counters for performance checks of the multi-cycle CPU.

---
 rtl/mem_responder.sv | 166 ++++++++++++++++
 tb/tb_mem_responder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: word-addressed 16-bit memory acting as the responder on the
// CPU memory bus. It serves fetches, loads and stores with a configurable
// read latency. It also has a preload port, saturating access counters and a
// sticky error flag.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   read_m, write_m       CPU read / write requests
//   address               16-bit word address (low ADDR_W bits index memory)
//   data                  bidirectional bus; driven only during a read response
//   mem_ready             read data valid on data this cycle
//   load_en/addr/data     preload write port (works during reset too)
//   read_count            completed reads, saturating
//   write_count           accepted writes, saturating
//   err                   sticky protocol / range error
module mem_responder #(
  parameter int ADDR_W       = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        read_m,
  input  logic        write_m,
  input  logic [15:0] address,
  inout  wire  [15:0] data,
  output logic        mem_ready,
  input  logic        load_en,
  input  logic [15:0] load_addr,
  input  logic [15:0] load_data,
  output logic [15:0] read_count,
  output logic [15:0] write_count,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [15:0] mem [DEPTH];

  function automatic logic in_rng(input logic [15:0] a);
    return (32'(a) >> ADDR_W) == 32'd0;
  endfunction

  logic rd_req, wr_req, conflict;
  assign rd_req   = read_m & ~write_m;
  // A coinciding preload takes the memory port, so the CPU write is dropped.
  assign wr_req   = write_m & ~read_m & ~load_en;
  assign conflict = read_m & write_m;

  // Upper preload address bits are deliberately ignored.
  logic unused_load_hi;
  assign unused_load_hi = ^load_addr;

  // Memory is never cleared; preload is honoured even while in reset.
  always_ff @(posedge clk) begin
    if (load_en)
      mem[load_addr[ADDR_W-1:0]] <= load_data;
    else if (reset_n && wr_req && in_rng(address))
      mem[address[ADDR_W-1:0]] <= data;
  end

  logic        drive;
  logic        rd_done;
  logic        rd_oor;
  logic [15:0] rdata;

  generate
    if (READ_LATENCY == 0) begin : g_comb
      assign drive   = reset_n & rd_req;
      assign rdata   = in_rng(address) ? mem[address[ADDR_W-1:0]] : 16'h0000;
      assign rd_done = drive;
      assign rd_oor  = drive & ~in_rng(address);
    end else begin : g_fsm
      typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

      state_t      state_q;
      logic [1:0]  cnt_q;
      logic [15:0] addr_q;
      logic [15:0] rdata_q;
      logic        ready_q;
      logic        enter_resp;
      logic [15:0] resp_addr;

      // cnt is loaded with READ_LATENCY-1 and counts down once per WAIT edge;
      // the edge on which it runs out is the edge that enters RESP, which
      // places mem_ready READ_LATENCY cycles after acceptance.
      always_comb begin
        resp_addr  = (state_q == IDLE) ? address : addr_q;
        enter_resp = rd_req && (((state_q == IDLE) && (READ_LATENCY == 1)) ||
                                ((state_q == WAIT) && (cnt_q == 2'd1)));
      end

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          state_q <= IDLE;
          cnt_q   <= 2'd0;
          addr_q  <= 16'h0000;
          rdata_q <= 16'h0000;
          ready_q <= 1'b0;
        end else begin
          ready_q <= 1'b0;
          case (state_q)
            IDLE: if (rd_req) begin
              addr_q  <= address;
              cnt_q   <= 2'(READ_LATENCY - 1);
              state_q <= (READ_LATENCY == 1) ? RESP : WAIT;
            end
            // Dropping read_m (or a read/write conflict) aborts silently.
            WAIT: if (!rd_req)            state_q <= IDLE;
                  else if (cnt_q == 2'd1) begin
                    state_q <= RESP;
                    cnt_q   <= 2'd0;
                  end else                cnt_q   <= cnt_q - 2'd1;
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
          endcase
          if (enter_resp) begin
            ready_q <= 1'b1;
            rdata_q <= in_rng(resp_addr) ? mem[resp_addr[ADDR_W-1:0]] : 16'h0000;
          end
        end
      end

      // The bus is never driven while the CPU asserts write_m.
      assign drive   = ready_q & ~write_m;
      assign rdata   = rdata_q;
      assign rd_done = drive;
      assign rd_oor  = enter_resp & ~in_rng(resp_addr);
    end
  endgenerate

  assign data      = drive ? rdata : 16'hzzzz;
  assign mem_ready = drive;

  logic [15:0] read_count_d, read_count_q;
  logic [15:0] write_count_d, write_count_q;
  logic        err_d, err_q;

  always_comb begin
    read_count_d  = read_count_q;
    write_count_d = write_count_q;
    err_d         = err_q;
    if (rd_done && read_count_q != 16'hFFFF)
      read_count_d = read_count_q + 16'd1;
    if (wr_req && in_rng(address) && write_count_q != 16'hFFFF)
      write_count_d = write_count_q + 16'd1;
    if ((wr_req && !in_rng(address)) || conflict || rd_oor)
      err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      read_count_q  <= 16'h0000;
      write_count_q <= 16'h0000;
      err_q         <= 1'b0;
    end else begin
      read_count_q  <= read_count_d;
      write_count_q <= write_count_d;
      err_q         <= err_d;
    end
  end

  assign read_count  = read_count_q;
  assign write_count = write_count_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances with READ_LATENCY 2, 1 and 0, each
// with its own stimulus, compared against a transaction-level model
// (memory array, counters, sticky error flag). The data buses are pulled
// high, so an undriven bus reads as 16'hFFFF.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [2:0]  rd, wr, ld, drv;
  logic [15:0] addr [3];
  logic [15:0] wdat [3];
  logic [15:0] ldaddr [3];
  logic [15:0] lddat [3];
  tri1  [15:0] bus0, bus1, bus2;
  logic [2:0]  rdy, er;
  logic [15:0] rc [3];
  logic [15:0] wc [3];

  assign bus0 = drv[0] ? wdat[0] : 16'hzzzz;
  assign bus1 = drv[1] ? wdat[1] : 16'hzzzz;
  assign bus2 = drv[2] ? wdat[2] : 16'hzzzz;

  mem_responder #(.ADDR_W(8), .READ_LATENCY(2)) u_lat2 (
    .clk(clk), .reset_n(reset_n), .read_m(rd[0]), .write_m(wr[0]), .address(addr[0]),
    .data(bus0), .mem_ready(rdy[0]), .load_en(ld[0]), .load_addr(ldaddr[0]),
    .load_data(lddat[0]), .read_count(rc[0]), .write_count(wc[0]), .err(er[0]));

  mem_responder #(.ADDR_W(8), .READ_LATENCY(1)) u_lat1 (
    .clk(clk), .reset_n(reset_n), .read_m(rd[1]), .write_m(wr[1]), .address(addr[1]),
    .data(bus1), .mem_ready(rdy[1]), .load_en(ld[1]), .load_addr(ldaddr[1]),
    .load_data(lddat[1]), .read_count(rc[1]), .write_count(wc[1]), .err(er[1]));

  mem_responder #(.ADDR_W(8), .READ_LATENCY(0)) u_lat0 (
    .clk(clk), .reset_n(reset_n), .read_m(rd[2]), .write_m(wr[2]), .address(addr[2]),
    .data(bus2), .mem_ready(rdy[2]), .load_en(ld[2]), .load_addr(ldaddr[2]),
    .load_data(lddat[2]), .read_count(rc[2]), .write_count(wc[2]), .err(er[2]));

  // Reference model
  int          lat_of [3] = '{2, 1, 0};
  logic [15:0] mdl [3][256];
  logic [15:0] rcm [3];
  logic [15:0] wcm [3];
  logic        errm [3];

  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] bus(input int i);
    case (i)
      0:       return bus0;
      1:       return bus1;
      default: return bus2;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mdl_read(input int i, input logic [15:0] a, output logic [15:0] exp);
    if (a[15:8] == 8'h00) exp = mdl[i][a[7:0]];
    else begin exp = 16'h0000; errm[i] = 1'b1; end
    if (rcm[i] != 16'hFFFF) rcm[i] = rcm[i] + 16'd1;
  endtask

  task automatic mdl_write(input int i, input logic [15:0] a, input logic [15:0] d);
    if (a[15:8] == 8'h00) begin
      mdl[i][a[7:0]] = d;
      if (wcm[i] != 16'hFFFF) wcm[i] = wcm[i] + 16'd1;
    end else errm[i] = 1'b1;
  endtask

  task automatic do_write(input int i, input logic [15:0] a, input logic [15:0] d);
    addr[i] = a; wdat[i] = d; drv[i] = 1'b1; wr[i] = 1'b1;
    tick();
    wr[i] = 1'b0; drv[i] = 1'b0;
  endtask

  // Returns the data seen while mem_ready was high and the number of edges
  // from acceptance to mem_ready (-1 if it never came within the budget).
  task automatic do_read(input int i, input logic [15:0] a,
                         output logic [15:0] got, output int lat);
    got = 16'hxxxx; lat = -1;
    addr[i] = a; rd[i] = 1'b1;
    if (lat_of[i] == 0) begin
      #1;
      if (rdy[i]) begin got = bus(i); lat = 0; end
      tick();
      rd[i] = 1'b0;
    end else begin
      for (int k = 1; k <= 6 && lat < 0; k++) begin
        tick();
        if (rdy[i]) begin got = bus(i); lat = k; rd[i] = 1'b0; end
      end
      rd[i] = 1'b0;
      if (lat >= 0) tick();
    end
  endtask

  task automatic clear_model_counters;
    for (int i = 0; i < 3; i++) begin rcm[i] = 0; wcm[i] = 0; errm[i] = 1'b0; end
  endtask

  task automatic test_reset;
    logic [15:0] d;
    reset_n = 1'b0;
    ld = 3'b111;
    for (int a = 0; a < 256; a++) begin
      for (int i = 0; i < 3; i++) begin
        d = (a == 5) ? 16'hA5A5 : 16'($urandom);
        ldaddr[i] = {8'($urandom), 8'(a)};
        lddat[i]  = d;
        mdl[i][a] = d;
      end
      tick();
    end
    ld = 3'b000;
    tick();
    clear_model_counters();
    for (int i = 0; i < 3; i++) begin
      checks++; if (rdy[i] !== 1'b0) begin errors++; $display("FAIL reset_ready[%0d]: got %b want 0", i, rdy[i]); end
      checks++; if (bus(i) !== 16'hFFFF) begin errors++; $display("FAIL reset_bus_z[%0d]: got %h want undriven", i, bus(i)); end
      checks++; if (rc[i] !== 16'h0) begin errors++; $display("FAIL reset_rcount[%0d]: got %h want 0", i, rc[i]); end
      checks++; if (wc[i] !== 16'h0) begin errors++; $display("FAIL reset_wcount[%0d]: got %h want 0", i, wc[i]); end
      checks++; if (er[i] !== 1'b0) begin errors++; $display("FAIL reset_err[%0d]: got %b want 0", i, er[i]); end
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_preload_read;
    logic [15:0] got, exp; int lat;
    do_read(0, 16'd5, got, lat);
    mdl_read(0, 16'd5, exp);
    checks++; if (got !== exp) begin errors++; $display("FAIL preload_data: got %h want %h", got, exp); end
    checks++; if (lat != 2) begin errors++; $display("FAIL preload_latency: got %0d want 2", lat); end
    checks++; if (rc[0] !== rcm[0]) begin errors++; $display("FAIL preload_rcount: got %h want %h", rc[0], rcm[0]); end
  endtask

  task automatic test_write_read;
    logic [15:0] got, exp, a, d; int lat, i;
    do_write(0, 16'd7, 16'h1234); mdl_write(0, 16'd7, 16'h1234);
    do_read(0, 16'd7, got, lat);  mdl_read(0, 16'd7, exp);
    checks++; if (got !== exp) begin errors++; $display("FAIL wr_rd_data: got %h want %h", got, exp); end
    checks++; if (wc[0] !== wcm[0]) begin errors++; $display("FAIL wr_rd_wcount: got %h want %h", wc[0], wcm[0]); end
    checks++; if (er[0] !== 1'b0) begin errors++; $display("FAIL wr_rd_err: got %b want 0", er[0]); end
    for (int n = 0; n < 24; n++) begin
      i = int'($urandom_range(0, 2));
      a = 16'($urandom_range(0, 255));
      d = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        do_write(i, a, d); mdl_write(i, a, d);
      end else begin
        do_read(i, a, got, lat); mdl_read(i, a, exp);
        checks++; if (got !== exp || lat != lat_of[i])
          begin errors++; $display("FAIL rand_read[%0d] @%h: got %h lat %0d want %h lat %0d", i, a, got, lat, exp, lat_of[i]); end
      end
    end
    for (int k = 0; k < 3; k++) begin
      checks++; if (rc[k] !== rcm[k] || wc[k] !== wcm[k])
        begin errors++; $display("FAIL rand_counts[%0d]: got r%h w%h want r%h w%h", k, rc[k], wc[k], rcm[k], wcm[k]); end
    end
  endtask

  task automatic test_out_of_range;
    logic [15:0] got, exp; int lat;
    do_read(0, 16'h0100, got, lat); mdl_read(0, 16'h0100, exp);
    checks++; if (got !== exp) begin errors++; $display("FAIL oor_read_data: got %h want %h", got, exp); end
    checks++; if (er[0] !== 1'b1) begin errors++; $display("FAIL oor_read_err: got %b want 1", er[0]); end
    do_write(0, 16'h0100, 16'hDEAD); mdl_write(0, 16'h0100, 16'hDEAD);
    checks++; if (wc[0] !== wcm[0]) begin errors++; $display("FAIL oor_write_wcount: got %h want %h", wc[0], wcm[0]); end
    do_read(0, 16'h0000, got, lat); mdl_read(0, 16'h0000, exp);
    checks++; if (got !== exp) begin errors++; $display("FAIL oor_write_alias: got %h want %h", got, exp); end
  endtask

  task automatic test_conflict;
    logic [15:0] got, exp, x, y, a11; int lat;
    addr[1] = 16'd9; wdat[1] = 16'hBEEF; drv[1] = 1'b1; rd[1] = 1'b1; wr[1] = 1'b1;
    #1;
    checks++; if (rdy[1] !== 1'b0 || bus1 !== 16'hBEEF)
      begin errors++; $display("FAIL conflict_bus: got rdy %b bus %h want 0 BEEF", rdy[1], bus1); end
    tick();
    rd[1] = 1'b0; wr[1] = 1'b0; drv[1] = 1'b0;
    errm[1] = 1'b1;
    checks++; if (er[1] !== 1'b1) begin errors++; $display("FAIL conflict_err: got %b want 1", er[1]); end
    checks++; if (wc[1] !== wcm[1]) begin errors++; $display("FAIL conflict_wcount: got %h want %h", wc[1], wcm[1]); end
    do_read(1, 16'd9, got, lat); mdl_read(1, 16'd9, exp);
    checks++; if (got !== exp) begin errors++; $display("FAIL conflict_mem: got %h want %h", got, exp); end
    // preload and CPU write in the same cycle on the zero-latency instance
    x = 16'($urandom); y = 16'($urandom); a11 = mdl[2][11];
    ld[2] = 1'b1; ldaddr[2] = 16'd10; lddat[2] = x;
    addr[2] = 16'd11; wdat[2] = y; drv[2] = 1'b1; wr[2] = 1'b1;
    tick();
    ld[2] = 1'b0; wr[2] = 1'b0; drv[2] = 1'b0;
    mdl[2][10] = x;
    checks++; if (wc[2] !== wcm[2] || er[2] !== errm[2])
      begin errors++; $display("FAIL preload_wins_counts: got w%h e%b want w%h e%b", wc[2], er[2], wcm[2], errm[2]); end
    do_read(2, 16'd10, got, lat); mdl_read(2, 16'd10, exp);
    checks++; if (got !== exp) begin errors++; $display("FAIL preload_wins_data: got %h want %h", got, exp); end
    do_read(2, 16'd11, got, lat); mdl_read(2, 16'd11, exp);
    checks++; if (got !== a11) begin errors++; $display("FAIL preload_wins_drop: got %h want %h", got, a11); end
  endtask

  task automatic test_abort;
    addr[0] = 16'd5; rd[0] = 1'b1;
    tick();
    rd[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL abort_ready[%0d]: got %b want 0", k, rdy[0]); end
      tick();
    end
    checks++; if (rc[0] !== rcm[0]) begin errors++; $display("FAIL abort_rcount: got %h want %h", rc[0], rcm[0]); end
  endtask

  task automatic test_held_read;
    logic [15:0] a, exp;
    logic        want;
    a = 16'($urandom_range(0, 255));
    exp = mdl[1][a[7:0]];
    addr[1] = a; rd[1] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      want = (k % 2) == 1;
      checks++; if (rdy[1] !== want || (want && bus1 !== exp))
        begin errors++; $display("FAIL held_read cycle %0d: got rdy %b data %h want rdy %b data %h", k + 1, rdy[1], bus1, want, exp); end
    end
    tick();
    rd[1] = 1'b0;
    rcm[1] = rcm[1] + 16'd3;
    checks++; if (rc[1] !== rcm[1]) begin errors++; $display("FAIL held_read_rcount: got %h want %h", rc[1], rcm[1]); end
  endtask

  task automatic test_reset_mid_read;
    logic [15:0] got, exp; int lat;
    addr[0] = 16'd5; rd[0] = 1'b1;
    tick();
    reset_n = 1'b0;
    tick();
    rd[0] = 1'b0;
    clear_model_counters();
    for (int i = 0; i < 3; i++) begin
      checks++; if (rdy[i] !== 1'b0 || bus(i) !== 16'hFFFF)
        begin errors++; $display("FAIL midreset_bus[%0d]: got rdy %b bus %h want 0 undriven", i, rdy[i], bus(i)); end
      checks++; if (rc[i] !== 16'h0 || wc[i] !== 16'h0 || er[i] !== 1'b0)
        begin errors++; $display("FAIL midreset_state[%0d]: got r%h w%h e%b want zeros", i, rc[i], wc[i], er[i]); end
    end
    reset_n = 1'b1;
    tick();
    checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL midreset_no_resp: got %b want 0", rdy[0]); end
    do_read(0, 16'd5, got, lat); mdl_read(0, 16'd5, exp);
    checks++; if (got !== exp) begin errors++; $display("FAIL midreset_mem_kept: got %h want %h", got, exp); end
  endtask

  task automatic test_write_saturate;
    logic [15:0] d, got, exp; int lat;
    d = 16'($urandom);
    addr[2] = 16'd3; wdat[2] = d; drv[2] = 1'b1; wr[2] = 1'b1;
    repeat (65540) tick();
    wr[2] = 1'b0; drv[2] = 1'b0;
    mdl[2][3] = d;
    wcm[2] = 16'hFFFF;
    checks++; if (wc[2] !== wcm[2]) begin errors++; $display("FAIL wcount_saturate: got %h want %h", wc[2], wcm[2]); end
    do_write(2, 16'd4, 16'h5A5A); mdl_write(2, 16'd4, 16'h5A5A);
    checks++; if (wc[2] !== wcm[2]) begin errors++; $display("FAIL wcount_hold: got %h want %h", wc[2], wcm[2]); end
    do_read(2, 16'd3, got, lat); mdl_read(2, 16'd3, exp);
    checks++; if (got !== exp) begin errors++; $display("FAIL held_write_data: got %h want %h", got, exp); end
  endtask

  initial begin
    reset_n = 1'b0;
    rd = '0; wr = '0; ld = '0; drv = '0;
    for (int i = 0; i < 3; i++) begin
      addr[i] = '0; wdat[i] = '0; ldaddr[i] = '0; lddat[i] = '0;
    end
    test_reset();
    test_preload_read();
    test_write_read();
    test_out_of_range();
    test_conflict();
    test_abort();
    test_held_read();
    test_reset_mid_read();
    test_write_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
